// File: rtl/sigmoid_pwl_pipe_pkg.sv
// Shared constants and encodings for the PLAN sigmoid pipeline.
package sigmoid_pkg;

  // Per-beat function select, carried alongside the beat through the pipe.
  typedef enum logic {
    MODE_PLAN = 1'b0,
    MODE_HARD = 1'b1
  } mode_e;

  // PLAN segment picked from |x| in S1.
  typedef enum logic [1:0] {
    SEG_SAT = 2'd0,  // |x| >= 5.0
    SEG_HI  = 2'd1,  // |x| >= 2.375
    SEG_MID = 2'd2,  // |x| >= 1.0
    SEG_LO  = 2'd3   // |x| <  1.0
  } seg_e;

  // Fixed-point constants scaled by 2^f; f >= 5 keeps every value integral.
  function automatic int unsigned T5(input int unsigned f);
    return 32'd5 << f;
  endfunction

  function automatic int unsigned T2375(input int unsigned f);
    return 32'd19 << (f - 3);
  endfunction

  function automatic int unsigned T1(input int unsigned f);
    return 32'd1 << f;
  endfunction

  function automatic int unsigned C84375(input int unsigned f);
    return 32'd27 << (f - 5);
  endfunction

  function automatic int unsigned C625(input int unsigned f);
    return 32'd5 << (f - 3);
  endfunction

  function automatic int unsigned C05(input int unsigned f);
    return 32'd1 << (f - 1);
  endfunction

  function automatic int unsigned ONE(input int unsigned f);
    return 32'd1 << f;
  endfunction

endpackage

// File: rtl/sigmoid_pwl_pipe_lane.sv
// Per-lane combinational slices of the sigmoid datapath; the top registers
// between them.
module sigmoid_lane
  import sigmoid_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8
) (
  // S1 slice
  input  logic [DATA_W-1:0]        x,
  output logic [DATA_W-2:0]        s1_a,
  output seg_e                     s1_seg,
  // S2 slice
  input  logic [DATA_W-1:0]        s2_x,
  input  logic [DATA_W-2:0]        s2_a,
  input  seg_e                     s2_seg,
  input  mode_e                    s2_mode,
  output logic signed [DATA_W:0]   s2_y,
  // S3 slice
  input  logic signed [DATA_W:0]   s3_y,
  input  logic                     s3_sign,
  input  mode_e                    s3_mode,
  output logic [FRAC_W:0]          s3_out
);

  localparam int unsigned AW    = DATA_W - 1;
  localparam int unsigned YW    = DATA_W + 1;
  localparam int unsigned OUT_W = FRAC_W + 1;

  localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

  localparam logic [AW-1:0] T5_A    = AW'(T5(FRAC_W));
  localparam logic [AW-1:0] T2375_A = AW'(T2375(FRAC_W));
  localparam logic [AW-1:0] T1_A    = AW'(T1(FRAC_W));

  localparam logic signed [YW-1:0] ONE_Y    = YW'(ONE(FRAC_W));
  localparam logic signed [YW-1:0] C84375_Y = YW'(C84375(FRAC_W));
  localparam logic signed [YW-1:0] C625_Y   = YW'(C625(FRAC_W));
  localparam logic signed [YW-1:0] C05_Y    = YW'(C05(FRAC_W));

  logic signed [YW-1:0] a_ext;
  logic signed [YW-1:0] x_ext;

  // S1: magnitude with the most-negative input pinned to max positive.
  always_comb begin
    s1_a = '0;
    if (!x[DATA_W-1]) begin
      s1_a = x[DATA_W-2:0];
    end else if (x == MOST_NEG) begin
      s1_a = '1;
    end else begin
      s1_a = AW'(-x);
    end
  end

  // S1: segment select against the scaled thresholds.
  always_comb begin
    s1_seg = SEG_LO;
    if (s1_a >= T5_A) begin
      s1_seg = SEG_SAT;
    end else if (s1_a >= T2375_A) begin
      s1_seg = SEG_HI;
    end else if (s1_a >= T1_A) begin
      s1_seg = SEG_MID;
    end
  end

  // S2: positive-half PLAN value or signed hard-sigmoid line.
  always_comb begin
    a_ext = $signed({2'b00, s2_a});
    x_ext = $signed({s2_x[DATA_W-1], s2_x});
    s2_y  = '0;
    if (s2_mode == MODE_HARD) begin
      s2_y = (x_ext >>> 2) + C05_Y;
    end else begin
      case (s2_seg)
        SEG_SAT: s2_y = ONE_Y;
        SEG_HI:  s2_y = (a_ext >>> 5) + C84375_Y;
        SEG_MID: s2_y = (a_ext >>> 3) + C625_Y;
        default: s2_y = (a_ext >>> 2) + C05_Y;
      endcase
    end
  end

  // S3: mirror negative inputs (PLAN) or clip to [0, 1.0] (hard).
  always_comb begin
    s3_out = '0;
    if (s3_mode == MODE_HARD) begin
      if (s3_y[YW-1]) begin
        s3_out = '0;
      end else if (s3_y > ONE_Y) begin
        s3_out = OUT_W'(ONE_Y);
      end else begin
        s3_out = OUT_W'(s3_y);
      end
    end else begin
      s3_out = s3_sign ? OUT_W'(ONE_Y - s3_y) : OUT_W'(s3_y);
    end
  end

endmodule

// File: rtl/sigmoid_pwl_pipe.sv
// Multi-lane PLAN / hard sigmoid, three pipeline stages with valid/ready
// back-pressure and a saturated-lane event counter.
module sigmoid_pwl_pipe
  import sigmoid_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 8,
  parameter int unsigned LANES  = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_mode,
  input  logic [LANES*DATA_W-1:0]       in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*(FRAC_W+1)-1:0]   out_data,
  input  logic                          sat_clr,
  output logic [CNT_W-1:0]              sat_count
);

  localparam int unsigned OUT_W = FRAC_W + 1;
  localparam logic [OUT_W-1:0] ONE_OUT = OUT_W'(ONE(FRAC_W));

  // Stage load enables
  logic ld1, ld2, ld3;

  // S1 registers
  logic              v1;
  mode_e             s1_mode_q;
  logic [DATA_W-1:0] s1_x_q   [LANES];
  logic [DATA_W-2:0] s1_a_q   [LANES];
  seg_e              s1_seg_q [LANES];

  // S2 registers
  logic                   v2;
  mode_e                  s2_mode_q;
  logic signed [DATA_W:0] s2_y_q    [LANES];
  logic                   s2_sign_q [LANES];

  // Combinational lane slice outputs
  logic [DATA_W-2:0]      a_c   [LANES];
  seg_e                   seg_c [LANES];
  logic signed [DATA_W:0] y_c   [LANES];
  logic [OUT_W-1:0]       out_c [LANES];

  // Counter helpers
  int unsigned      sat_lanes;
  logic [CNT_W:0]   sat_sum;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sigmoid_lane #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W)
    ) u_lane (
      .x       (in_data[g*DATA_W +: DATA_W]),
      .s1_a    (a_c[g]),
      .s1_seg  (seg_c[g]),
      .s2_x    (s1_x_q[g]),
      .s2_a    (s1_a_q[g]),
      .s2_seg  (s1_seg_q[g]),
      .s2_mode (s1_mode_q),
      .s2_y    (y_c[g]),
      .s3_y    (s2_y_q[g]),
      .s3_sign (s2_sign_q[g]),
      .s3_mode (s2_mode_q),
      .s3_out  (out_c[g])
    );
  end

  // Ready chain: a stage loads when empty or when its successor loads, so
  // bubbles collapse and a full pipe streams one beat per cycle.
  always_comb begin
    ld3      = !out_valid || out_ready;
    ld2      = !v2 || ld3;
    ld1      = !v1 || ld2;
    in_ready = ld1;
  end

  // S1 register: raw input (sign comes from its MSB), magnitude, segment, mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1        <= 1'b0;
      s1_mode_q <= MODE_PLAN;
      for (int unsigned i = 0; i < LANES; i++) begin
        s1_x_q[i]   <= '0;
        s1_a_q[i]   <= '0;
        s1_seg_q[i] <= SEG_LO;
      end
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1_mode_q <= mode_e'(in_mode);
        for (int unsigned i = 0; i < LANES; i++) begin
          s1_x_q[i]   <= in_data[i*DATA_W +: DATA_W];
          s1_a_q[i]   <= a_c[i];
          s1_seg_q[i] <= seg_c[i];
        end
      end
    end
  end

  // S2 register: pre-finish value, sign and mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2        <= 1'b0;
      s2_mode_q <= MODE_PLAN;
      for (int unsigned i = 0; i < LANES; i++) begin
        s2_y_q[i]    <= '0;
        s2_sign_q[i] <= 1'b0;
      end
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2_mode_q <= s1_mode_q;
        for (int unsigned i = 0; i < LANES; i++) begin
          s2_y_q[i]    <= y_c[i];
          s2_sign_q[i] <= s1_x_q[i][DATA_W-1];
        end
      end
    end
  end

  // S3 register: drives the output port and holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (ld3) begin
      out_valid <= v2;
      if (v2) begin
        for (int unsigned i = 0; i < LANES; i++) begin
          out_data[i*OUT_W +: OUT_W] <= out_c[i];
        end
      end
    end
  end

  // Count lanes of the current output beat sitting at 0 or 1.0.
  always_comb begin
    sat_lanes = 0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (out_data[i*OUT_W +: OUT_W] == '0 || out_data[i*OUT_W +: OUT_W] == ONE_OUT) begin
        sat_lanes = sat_lanes + 1;
      end
    end
    sat_sum = {1'b0, sat_count} + (CNT_W+1)'(sat_lanes);
  end

  // Saturating event counter; clear wins over an increment in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (out_valid && out_ready) begin
      sat_count <= sat_sum[CNT_W] ? '1 : sat_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_sigmoid_pwl_pipe.sv
// Self-checking bench for sigmoid_pwl_pipe (DATA_W=16, FRAC_W=8, LANES=4).
module tb_sigmoid_pwl_pipe;

  localparam int DW = 16;
  localparam int FW = 8;
  localparam int L  = 4;
  localparam int OW = FW + 1;
  localparam int ONE_V = 1 << FW;
  localparam int MAXP  = (1 << (DW - 1)) - 1;
  localparam int CMAX  = 65535;

  logic            clk;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic            in_mode;
  logic [L*DW-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [L*OW-1:0] out_data;
  logic            sat_clr;
  logic [15:0]     sat_count;

  sigmoid_pwl_pipe #(
    .DATA_W (DW),
    .FRAC_W (FW),
    .LANES  (L),
    .CNT_W  (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .sat_clr   (sat_clr),
    .sat_count (sat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [L*OW-1:0] data;
    int              nsat;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;
  int   fails  = 0;
  int   exp_sat = 0;
  bit   rand_ready = 0;

  // Reference: sigmoid rules evaluated with plain integer arithmetic.
  function automatic int ref_sig(int x, bit mode);
    int a, y;
    if (!mode) begin
      a = (x < 0) ? -x : x;
      if (a > MAXP) a = MAXP;
      if (a >= 5 * ONE_V)          y = ONE_V;
      else if (a * 8 >= 19 * ONE_V) y = a / 32 + (27 * ONE_V) / 32;
      else if (a >= ONE_V)          y = a / 8 + (5 * ONE_V) / 8;
      else                          y = a / 4 + ONE_V / 2;
      return (x < 0) ? ONE_V - y : y;
    end
    y = (x >= 0) ? x / 4 : -((-x + 3) / 4);
    y = y + ONE_V / 2;
    if (y < 0) y = 0;
    if (y > ONE_V) y = ONE_V;
    return y;
  endfunction

  function automatic logic [L*OW-1:0] ref_beat(logic [L*DW-1:0] d, bit mode);
    logic [L*OW-1:0] r;
    logic [DW-1:0]   lane;
    r = '0;
    for (int i = 0; i < L; i++) begin
      lane = d[i*DW +: DW];
      r[i*OW +: OW] = OW'(ref_sig(int'($signed(lane)), mode));
    end
    return r;
  endfunction

  function automatic int count_sat(logic [L*OW-1:0] d);
    int n = 0;
    for (int i = 0; i < L; i++) begin
      if (int'(d[i*OW +: OW]) == 0 || int'(d[i*OW +: OW]) == ONE_V) n++;
    end
    return n;
  endfunction

  function automatic logic [L*DW-1:0] pack_in(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [L*OW-1:0] pack_out(int a, int b, int c, int d);
    return {9'(d), 9'(c), 9'(b), 9'(a)};
  endfunction

  function automatic logic [L*DW-1:0] rand_data();
    logic [L*DW-1:0] r;
    for (int i = 0; i < L; i++) begin
      if ($urandom_range(0, 1) == 1) r[i*DW +: DW] = 16'($urandom);
      else r[i*DW +: DW] = 16'(int'($urandom_range(0, 3200)) - 1600);
    end
    return r;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] expv);
    checks++;
    assert (obs === expv) begin
      passed++;
    end else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer one beat, wait (bounded) for acceptance, then log its expectation.
  task automatic send(logic [L*DW-1:0] d, bit m, logic [L*OW-1:0] e);
    exp_t x;
    bit   done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    for (int n = 0; n < 200 && !done; n++) begin
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (in_ready) begin
        x.data = e;
        x.nsat = count_sat(e);
        q.push_back(x);
        done = 1;
      end
      step();
    end
    in_valid = 1'b0;
    check("in_accept", 64'(done), 1);
  endtask

  task automatic drain();
    rand_ready = 0;
    out_ready  = 1'b1;
    for (int n = 0; n < 300 && q.size() != 0; n++) step();
    check("drain_empty", 64'(q.size()), 0);
    repeat (3) step();
  endtask

  // Output monitor: ordering, data, hold stability and counter model.
  exp_t            mon_e;
  int              mon_nsat;
  int              mon_tmp;
  bit              held_pending = 0;
  logic [L*OW-1:0] held_data;

  always @(negedge clk) begin
    if (!rst_n) begin
      held_pending = 0;
    end else begin
      if (held_pending && out_valid) check("hold_stable", 64'(out_data), 64'(held_data));
      check("sat_count", 64'(sat_count), 64'(exp_sat));
      mon_nsat = 0;
      if (out_valid && out_ready) begin
        check("out_expected", 64'(q.size() != 0), 1);
        if (q.size() != 0) begin
          mon_e = q.pop_front();
          check("out_data", 64'(out_data), 64'(mon_e.data));
          mon_nsat = mon_e.nsat;
        end
      end
      if (sat_clr) begin
        exp_sat = 0;
      end else if (out_valid && out_ready) begin
        mon_tmp = exp_sat + mon_nsat;
        exp_sat = (mon_tmp > CMAX) ? CMAX : mon_tmp;
      end
      held_pending = out_valid && !out_ready;
      held_data    = out_data;
    end
  end

  logic [L*DW-1:0] s_data [10];
  bit              s_mode [10];
  logic [L*DW-1:0] d;
  bit              m;
  int              idx, cyc;
  bit              saw_low;
  bit              got;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_mode = 1'b0; in_data = '0;
    out_ready = 1'b1; sat_clr = 1'b0;
    repeat (2) step();
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_sat_count", 64'(sat_count), 0);
    check("rst_in_ready", 64'(in_ready), 1);
    rst_n = 1'b1;
    step();

    // Directed beats with latency check on the first.
    send(pack_in(0, 256, -256, 128), 0, pack_out(128, 192, 64, 160));
    check("lat_cycle2", 64'(out_valid), 0);
    step();
    check("lat_cycle3", 64'(out_valid), 0);
    step();
    check("lat_cycle3_valid", 64'(out_valid), 1);
    drain();
    send(pack_in(768, 1280, -2048, -32768), 0, pack_out(240, 256, 0, 0));
    send(pack_in(256, 768, -768, 0), 1, pack_out(192, 256, 0, 128));
    drain();
    check("sat_after_directed", 64'(sat_count), 5);

    // Threshold boundaries in both modes.
    send(pack_in(1279, 1280, 607, 608), 0, pack_out(255, 256, 235, 235));
    send(pack_in(255, -1, 32767, -32767), 0, pack_out(191, 128, 256, 0));
    send(pack_in(-512, -513, 511, 513), 1, pack_out(0, 0, 255, 256));
    send(pack_in(1024, -32768, 32767, -1), 1, pack_out(256, 0, 256, 127));
    drain();

    // Ten back-to-back beats with the consumer stalled on cycles 4-7.
    for (int i = 0; i < 10; i++) begin
      s_data[i] = rand_data();
      s_mode[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; cyc = 0; saw_low = 0;
    while (idx < 10 && cyc < 100) begin
      out_ready = !(cyc >= 4 && cyc <= 7);
      in_valid  = 1'b1;
      in_data   = s_data[idx];
      in_mode   = s_mode[idx];
      @(negedge clk);
      if (in_ready) begin
        q.push_back('{ref_beat(s_data[idx], s_mode[idx]), count_sat(ref_beat(s_data[idx], s_mode[idx]))});
        idx++;
      end else begin
        saw_low = 1;
      end
      step();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("stream_accepted", 64'(idx), 10);
    check("in_ready_dropped", 64'(saw_low), 1);
    drain();

    // Random traffic with random consumer back-pressure.
    rand_ready = 1;
    for (int i = 0; i < 150; i++) begin
      d = rand_data();
      m = 1'($urandom_range(0, 1));
      send(d, m, ref_beat(d, m));
      repeat ($urandom_range(0, 2)) begin
        out_ready = 1'($urandom_range(0, 1));
        step();
      end
    end
    drain();

    // Clear in the same cycle as a saturating output transfer.
    send(pack_in(32767, 32767, 32767, 32767), 0, pack_out(256, 256, 256, 256));
    got = 0;
    for (int n = 0; n < 10 && !got; n++) begin
      if (out_valid) got = 1;
      else step();
    end
    check("sat_clr_wait", 64'(out_valid), 1);
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    check("sat_clr_priority", 64'(sat_count), 0);
    drain();

    // Asynchronous reset with beats stuck in the pipe.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      d = rand_data();
      send(d, 0, ref_beat(d, 0));
    end
    step();
    check("pre_reset_valid", 64'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 0);
    check("mid_rst_out_data", 64'(out_data), 0);
    check("mid_rst_sat", 64'(sat_count), 0);
    check("mid_rst_in_ready", 64'(in_ready), 1);
    q.delete();
    exp_sat = 0;
    #3 rst_n = 1'b1;
    step();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = rand_data();
      m = 1'($urandom_range(0, 1));
      send(d, m, ref_beat(d, m));
    end
    drain();

    // Drive the counter into saturation with all-lane saturating beats.
    sat_clr = 1'b1;
    step();
    sat_clr = 1'b0;
    for (int i = 0; i < 16400; i++) begin
      if (i % 2 == 0) send(pack_in(32767, 32767, 32767, 32767), 0, pack_out(256, 256, 256, 256));
      else send(pack_in(-32768, -32768, -32768, -32768), 0, pack_out(0, 0, 0, 0));
    end
    drain();
    check("sat_held_max", 64'(sat_count), 64'hFFFF);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
